fifo_uart_tx: RTL and testbench



---
 rtl/fifo_uart_tx_pkg.sv | 20 ++
 rtl/uart_bit_timer.sv | 34 +++
 rtl/fifo_uart_tx.sv | 130 +++++++++++++
 tb/tb_fifo_uart_tx.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_tx_pkg.sv
// Shared UART definitions: state encoding and byte width, also used by the matching receiver.
// Optional parity stage is enabled by defining FIFO_UART_TX_PARITY_EN.
package fifo_uart_tx_pkg;

    localparam int UART_STATE_W = 3;
    localparam int UART_BYTE_W  = 8;

    typedef enum logic [UART_STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    function automatic logic even_parity(input logic [UART_BYTE_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..DIVISOR-1 while enabled, ticks on the last cycle,
// and restarts from zero on load or when disabled.
module uart_bit_timer #(
    parameter int DIVISOR  = 32,
    parameter int DIV_BITS = $clog2(DIVISOR + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic load,
    output logic tick
);

    logic [DIV_BITS-1:0] cnt_q;
    logic [DIV_BITS-1:0] cnt_d;

    assign tick = en && (cnt_q == DIV_BITS'(DIVISOR - 1));

    always_comb begin
        cnt_d = cnt_q + DIV_BITS'(1);
        if (!en || load || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// FWFT FIFO drain that serialises bytes as UART 8N1 with back-to-back framing.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between DATA and STOP.
module fifo_uart_tx #(
    parameter int DIVISOR  = 32,
    parameter int DIV_BITS = $clog2(DIVISOR + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fifo_data_available,
    input  logic [7:0]  fifo_read_data,
    output logic        fifo_read_strobe,
    output logic        serial_txd,
    output logic        busy,
    output logic [15:0] frames_sent
);

    import fifo_uart_tx_pkg::*;

    uart_state_e            state_q, state_d;
    logic [UART_BYTE_W-1:0] shift_q, shift_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [15:0]            frames_sent_q, frames_sent_d;
    logic                   txd_q, txd_d;
    logic                   busy_q, busy_d;
    logic                   bit_tick;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    uart_bit_timer #(
        .DIVISOR  (DIVISOR),
        .DIV_BITS (DIV_BITS)
    ) u_bit_timer (
        .clk   (clk),
        .reset (reset),
        .en    (state_q != ST_IDLE),
        .load  (fifo_read_strobe),
        .tick  (bit_tick)
    );

    always_comb begin
        fifo_read_strobe = fifo_data_available &&
                           ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_tick));

        state_d       = state_q;
        shift_d       = shift_q;
        bit_idx_d     = bit_idx_q;
        frames_sent_d = frames_sent_q;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d      = parity_q;
`endif

        case (state_q)
            ST_IDLE: ;
            ST_START: if (bit_tick) state_d = ST_DATA;
            ST_DATA: begin
                if (bit_tick) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: if (bit_tick) state_d = ST_STOP;
`endif
            ST_STOP: begin
                if (bit_tick) begin
                    frames_sent_d = frames_sent_q + 16'd1;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A pop overrides the STOP->IDLE exit so frames chain with no idle gap.
        if (fifo_read_strobe) begin
            state_d   = ST_START;
            shift_d   = fifo_read_data;
            bit_idx_d = 3'd0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_d  = even_parity(fifo_read_data);
`endif
        end

        case (state_d)
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: txd_d = parity_d;
`endif
            default:  txd_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            shift_q       <= '0;
            bit_idx_q     <= '0;
            frames_sent_q <= '0;
            txd_q         <= 1'b1;
            busy_q        <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            bit_idx_q     <= bit_idx_d;
            frames_sent_q <= frames_sent_d;
            txd_q         <= txd_d;
            busy_q        <= busy_d;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q      <= parity_d;
`endif
        end
    end

    assign serial_txd  = txd_q;
    assign busy        = busy_q;
    assign frames_sent = frames_sent_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FWFT FIFO model plus an ideal-waveform reference for UART framing.
module tb_fifo_uart_tx;

    localparam int DIV = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int F = NBITS * DIV;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fifo_data_available = 1'b0;
    logic [7:0]  fifo_read_data = 8'h00;
    logic        fifo_read_strobe;
    logic        serial_txd;
    logic        busy;
    logic [15:0] frames_sent;

    fifo_uart_tx #(.DIVISOR(DIV)) dut (
        .clk                 (clk),
        .reset               (reset),
        .fifo_data_available (fifo_data_available),
        .fifo_read_data      (fifo_read_data),
        .fifo_read_strobe    (fifo_read_strobe),
        .serial_txd          (serial_txd),
        .busy                (busy),
        .frames_sent         (frames_sent)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  fifo_q[$];
    logic [7:0]  tx_bytes[$];
    logic [15:0] frames_base = 16'h0000;
    logic        s_txd, s_busy, s_stb;
    logic [15:0] s_frames;

    task automatic update_fifo();
        fifo_data_available = (fifo_q.size() != 0);
        fifo_read_data      = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    // Sample one clock cycle mid-period, then apply the FIFO pop after the edge.
    task automatic cycle();
        @(negedge clk);
        s_txd = serial_txd; s_busy = busy; s_stb = fifo_read_strobe; s_frames = frames_sent;
        @(posedge clk); #1;
        if (s_stb && fifo_q.size() != 0) void'(fifo_q.pop_front());
        update_fifo();
    endtask

    // Ideal line level for bit slot bitn of a frame carrying byte d.
    function automatic logic model_bit(input logic [7:0] d, input int bitn);
        if (bitn == 0) return 1'b0;
        if (bitn <= 8) return d[bitn-1];
`ifdef FIFO_UART_TX_PARITY_EN
        if (bitn == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    // Preload tx_bytes into the idle FIFO and check every cycle of the resulting burst.
    task automatic test_stream(input string name);
        int n;
        logic exp_txd, exp_busy, exp_stb;
        logic [15:0] exp_frames;
        n = tx_bytes.size();
        fifo_q = tx_bytes;
        update_fifo();
        for (int c = 0; c <= n*F + 3; c++) begin
            cycle();
            exp_stb  = (c % F == 0) && (c / F < n);
            exp_busy = (c >= 1) && (c <= n*F);
            exp_txd  = exp_busy ? model_bit(tx_bytes[(c-1)/F], ((c-1)%F)/DIV) : 1'b1;
            exp_frames = frames_base + 16'((c == 0) ? 0 : (((c-1)/F) < n ? (c-1)/F : n));
            checks += 4;
            if (s_stb !== exp_stb) begin
                failures++; $display("FAIL %s strobe cyc=%0d got=%b exp=%b", name, c, s_stb, exp_stb);
            end
            if (s_busy !== exp_busy) begin
                failures++; $display("FAIL %s busy cyc=%0d got=%b exp=%b", name, c, s_busy, exp_busy);
            end
            if (s_txd !== exp_txd) begin
                failures++; $display("FAIL %s txd cyc=%0d got=%b exp=%b", name, c, s_txd, exp_txd);
            end
            if (s_frames !== exp_frames) begin
                failures++; $display("FAIL %s frames cyc=%0d got=%h exp=%h", name, c, s_frames, exp_frames);
            end
        end
        frames_base = frames_base + 16'(n);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) cycle();
        checks += 4;
        if (s_txd !== 1'b1) begin failures++; $display("FAIL reset txd got=%b exp=1", s_txd); end
        if (s_busy !== 1'b0) begin failures++; $display("FAIL reset busy got=%b exp=0", s_busy); end
        if (s_stb !== 1'b0) begin failures++; $display("FAIL reset strobe got=%b exp=0", s_stb); end
        if (s_frames !== 16'h0) begin failures++; $display("FAIL reset frames got=%h exp=0", s_frames); end
        reset = 1'b0;
        frames_base = 16'h0000;
    endtask

    task automatic test_idle();
        for (int c = 0; c < 200; c++) begin
            cycle();
            checks++;
            if (s_stb !== 1'b0 || s_txd !== 1'b1 || s_busy !== 1'b0) begin
                failures++;
                $display("FAIL idle cyc=%0d stb/txd/busy got=%b%b%b exp=010", c, s_stb, s_txd, s_busy);
            end
        end
    endtask

    task automatic test_midframe_reset();
        fifo_q = '{8'h0F};
        update_fifo();
        for (int c = 0; c <= 2 + 4*DIV; c++) cycle();
        checks++;
        if (s_txd !== 1'b1 || s_busy !== 1'b1) begin
            failures++; $display("FAIL midreset bit3 txd/busy got=%b%b exp=11", s_txd, s_busy);
        end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        checks += 3;
        if (s_txd !== 1'b1) begin failures++; $display("FAIL midreset txd got=%b exp=1", s_txd); end
        if (s_busy !== 1'b0) begin failures++; $display("FAIL midreset busy got=%b exp=0", s_busy); end
        if (s_frames !== 16'h0) begin failures++; $display("FAIL midreset frames got=%h exp=0", s_frames); end
        frames_base = 16'h0000;
        tx_bytes = '{8'h81};
        test_stream("after_reset_81");
    endtask

    task automatic test_random();
        int n;
        tx_bytes = {};
        n = $urandom_range(2, 5);
        for (int i = 0; i < n; i++) tx_bytes.push_back(8'($urandom));
        test_stream("random");
    endtask

    task automatic test_wrap();
        force dut.frames_sent_q = 16'hFFFF;
        cycle();
        release dut.frames_sent_q;
        cycle();
        checks++;
        if (s_frames !== 16'hFFFF) begin failures++; $display("FAIL wrap preload got=%h exp=ffff", s_frames); end
        frames_base = 16'hFFFF;
        tx_bytes = '{8'($urandom)};
        test_stream("wrap");
        checks++;
        if (s_frames !== 16'h0000) begin failures++; $display("FAIL wrap final got=%h exp=0000", s_frames); end
    endtask

    initial begin
        test_reset();
        tx_bytes = '{8'h55};
        test_stream("single_55");
        tx_bytes = '{8'hA3, 8'h00, 8'hFF};
        test_stream("b2b_a3_00_ff");
        test_idle();
        test_midframe_reset();
        tx_bytes = '{8'h07, 8'h03};
        test_stream("parity_07_03");
        for (int r = 0; r < 4; r++) test_random();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
